// File: rtl/mchan_hs_pkg.sv
// Shared types and helpers for the multi-channel req/ack CDC transmit block.
package mchan_hs_pkg;

   // Default geometry of a transmit block instance.
   localparam int DW_DEF   = 8;
   localparam int NCH_DEF  = 4;
   localparam int SYNC_DEF = 2;

   // Handshake controller states. DROP is only visited in 4-phase mode.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } hs_state_e;

   // Width of a channel id. A single-channel block still carries a
   // one-bit id so the port never collapses to zero width.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mchan_hs_tx_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level (used for ack_i).
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous level through the chain; all flops clear on reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mchan_hs_tx.sv
// Source-domain half of a multi-channel req/ack CDC handshake.
// NCH valid/ready producers are arbitrated round-robin; the winning word and
// its channel id are held stable on data_o/chid_o while req_o crosses to the
// destination domain. ack_i is only ever looked at through a synchroniser.
//
// Producer handshake: a word moves on a rising clk_i edge where
// in_vld[c] & in_rdy[c] are both high. in_rdy never depends on anything but
// registered state, the synchronised ack and in_vld; a producer must keep
// din stable while in_vld is high, and may drop in_vld before it is served.
module mchan_hs_tx
   import mchan_hs_pkg::*;
#(
   parameter int DW          = DW_DEF,
   parameter int NCH         = NCH_DEF,
   parameter int SYNC_STAGES = SYNC_DEF,
   parameter int TWO_PHASE   = 0,
   parameter int TO_CYC      = 1024
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NCH-1:0]                in_vld,
   input  logic [NCH*DW-1:0]             din,
   output logic [NCH-1:0]                in_rdy,
   output logic                          req_o,
   output logic [DW-1:0]                 data_o,
   output logic [clog2_min1(NCH)-1:0]    chid_o,
   input  logic                          ack_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic [15:0]                   xfer_cnt,
   output hs_state_e                     dbg_state_o
);

   localparam int CW  = clog2_min1(NCH);
   localparam int TCW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;

   hs_state_e      state_q;
   logic           req_q;
   logic [DW-1:0]  data_q;
   logic [CW-1:0]  chid_q;
   logic [CW-1:0]  rr_q;
   logic           busy_q;
   logic           done_q;
   logic [15:0]    xfer_q;

   logic           ack_s;
   logic           rdy_ok;
   logic           gnt_vld;
   logic [CW-1:0]  gnt_idx;
   logic [DW-1:0]  gnt_data;
   logic           accept;
   logic           to_clr;
   logic           in_wait;

   // Bring the far-side acknowledge into this clock domain.
   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (ack_i),
      .q_o   (ack_s)
   );

   // The far side must have finished with the previous word before a new one
   // is offered: ack low in level mode, ack caught up with req in toggle mode.
   assign rdy_ok = (TWO_PHASE != 0) ? (ack_s == req_q) : !ack_s;

   // Round-robin pick: first requester at or after rr_q, wrapping. Scanning
   // offsets from the far end lets the nearest requester win the last write.
   always_comb begin
      int unsigned k;
      k        = 0;
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      gnt_data = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         k = (int'(rr_q) + i) % NCH;
         if (in_vld[k[CW-1:0]]) begin
            gnt_vld  = 1'b1;
            gnt_idx  = k[CW-1:0];
            gnt_data = din[k*DW +: DW];
         end
      end
   end

   // A word is taken only from IDLE, never in the cycle done_o is high, and
   // never while reset is applied.
   assign accept = !rst_i && (state_q == S_IDLE) && !done_q && rdy_ok && gnt_vld;

   // Ready is a one-hot echo of the grant and is zero outside IDLE.
   always_comb begin
      in_rdy = '0;
      if (accept) begin
         in_rdy[gnt_idx] = 1'b1;
      end
   end

   // Handshake controller: capture on accept, drive req, count completions.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
         chid_q  <= '0;
         rr_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         xfer_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  data_q  <= gnt_data;
                  chid_q  <= gnt_idx;
                  rr_q    <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
                  busy_q  <= 1'b1;
                  req_q   <= (TWO_PHASE != 0) ? ~req_q : 1'b1;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (TWO_PHASE != 0) begin
                  // Toggle mode: ack catching up with req closes the transfer.
                  if (ack_s == req_q) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     xfer_q  <= xfer_q + 16'd1;
                     state_q <= S_IDLE;
                  end
               end else if (ack_s) begin
                  // Level mode: far side has the word, withdraw the request.
                  req_q   <= 1'b0;
                  state_q <= S_DROP;
               end
            end
            S_DROP: begin
               // Level mode return-to-zero: complete once ack has fallen.
               if (!ack_s) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  xfer_q  <= xfer_q + 16'd1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Waiting on the far side restarts on entry to REQ (accept) or DROP.
   assign to_clr  = accept || ((state_q == S_REQ) && (TWO_PHASE == 0) && ack_s);
   assign in_wait = (state_q != S_IDLE);

   generate
      if (TO_CYC > 0) begin : g_to
         logic [TCW-1:0] to_cnt_q;
         logic           err_q;

         // Saturating wait counter; err is sticky and does not abort the transfer.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               to_cnt_q <= '0;
               err_q    <= 1'b0;
            end else if (to_clr) begin
               to_cnt_q <= '0;
            end else if (in_wait) begin
               if (to_cnt_q != TCW'(TO_CYC)) begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
               if (to_cnt_q == TCW'(TO_CYC - 1)) begin
                  err_q <= 1'b1;
               end
            end
         end

         assign err_o = err_q;
      end else begin : g_no_to
         assign err_o = 1'b0;
      end
   endgenerate

   assign req_o       = req_q;
   assign data_o      = data_q;
   assign chid_o      = chid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign xfer_cnt    = xfer_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mchan_hs_tx.sv
// Bench for mchan_hs_tx: a level-mode instance with a short timeout (a) and a
// toggle-mode instance without timeout (b), each with a delayed ack responder.
module tb_mchan_hs_tx;
   import mchan_hs_pkg::*;

   localparam int DW  = 8;
   localparam int NCH = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT a: 4-phase, TO_CYC=16 ----------------
   logic [NCH-1:0]    vld_a, rdy_a;
   logic [NCH*DW-1:0] din_a;
   logic              req_a, ack_a, busy_a, done_a, err_a;
   logic [DW-1:0]     data_a;
   logic [1:0]        chid_a;
   logic [15:0]       xfer_a;
   hs_state_e         st_a;

   mchan_hs_tx #(.DW(DW), .NCH(NCH), .SYNC_STAGES(2), .TWO_PHASE(0), .TO_CYC(16)) u_dut_a (
      .clk_i (clk), .rst_i (rst), .in_vld (vld_a), .din (din_a), .in_rdy (rdy_a),
      .req_o (req_a), .data_o (data_a), .chid_o (chid_a), .ack_i (ack_a),
      .busy_o (busy_a), .done_o (done_a), .err_o (err_a), .xfer_cnt (xfer_a),
      .dbg_state_o (st_a)
   );

   // ---------------- DUT b: 2-phase, no timeout ----------------
   logic [NCH-1:0]    vld_b, rdy_b;
   logic [NCH*DW-1:0] din_b;
   logic              req_b, ack_b, busy_b, done_b, err_b;
   logic [DW-1:0]     data_b;
   logic [1:0]        chid_b;
   logic [15:0]       xfer_b;
   hs_state_e         st_b;

   mchan_hs_tx #(.DW(DW), .NCH(NCH), .SYNC_STAGES(2), .TWO_PHASE(1), .TO_CYC(0)) u_dut_b (
      .clk_i (clk), .rst_i (rst), .in_vld (vld_b), .din (din_b), .in_rdy (rdy_b),
      .req_o (req_b), .data_o (data_b), .chid_o (chid_b), .ack_i (ack_b),
      .busy_o (busy_b), .done_o (done_b), .err_o (err_b), .xfer_cnt (xfer_b),
      .dbg_state_o (st_b)
   );

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard state ----------------
   logic [9:0]  exp_a[$];
   logic [9:0]  exp_b[$];
   logic [7:0]  src_a[NCH][$];
   logic [3:0]  fire_a = '0;
   int          rdy2_cnt = 0;
   int          xfer_model_a = 0;
   logic        prev_busy_a = 1'b0;
   logic        prev_done_a = 1'b0;
   logic [7:0]  held_a = '0;
   logic        resp_en_a = 1'b0;
   logic        resp_en_b = 1'b0;
   int          dly_a = 0;
   int          dly_b = 0;

   // ---------------- producer for a: per-channel word queues ----------------
   initial forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         if (fire_a[c] && src_a[c].size() > 0) void'(src_a[c].pop_front());
      end
      for (int c = 0; c < NCH; c++) begin
         if (src_a[c].size() > 0) begin
            vld_a[c] = 1'b1;
            din_a[c*DW +: DW] = src_a[c][0];
         end else begin
            vld_a[c] = 1'b0;
            din_a[c*DW +: DW] = '0;
         end
      end
      #1;
      fire_a = vld_a & rdy_a;
      if (rdy_a[2]) rdy2_cnt++;
   end

   // ---------------- far-side responders: ack follows req after 3 cycles ----------------
   initial forever begin
      @(negedge clk);
      if (resp_en_a) begin
         if (ack_a != req_a) begin
            if (dly_a == 2) begin ack_a = req_a; dly_a = 0; end
            else dly_a++;
         end else dly_a = 0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (resp_en_b) begin
         if (ack_b != req_b) begin
            if (dly_b == 2) begin ack_b = req_b; dly_b = 0; end
            else dly_b++;
         end else dly_b = 0;
      end
   end

   // ---------------- monitor for a: accepts, hold stability, completions ----------------
   initial forever begin
      logic [9:0] e;
      @(negedge clk);
      #2;
      if (!rst) begin
         if (busy_a && !prev_busy_a) begin
            if (exp_a.size() == 0) begin
               check_eq("a_unexpected_accept", exp_a.size(), 1);
            end else begin
               e = exp_a.pop_front();
               check_eq("a_accept", {chid_a, data_a}, e);
            end
            held_a = data_a;
         end else if (busy_a && prev_busy_a) begin
            check_eq("a_hold", data_a, held_a);
         end
         if (done_a) begin
            xfer_model_a++;
            check_eq("a_done_1cyc", prev_done_a, 0);
            check_eq("a_done_busy", busy_a, 0);
            check_eq("a_done_req", req_a, 0);
            check_eq("a_xfer_cnt", xfer_a, xfer_model_a);
         end
      end
      prev_busy_a = busy_a;
      prev_done_a = done_a;
   end

   // ---------------- driver tasks ----------------
   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_req_a"},  req_a,  0);
      check_eq({tag, "_busy_a"}, busy_a, 0);
      check_eq({tag, "_done_a"}, done_a, 0);
      check_eq({tag, "_err_a"},  err_a,  0);
      check_eq({tag, "_xfer_a"}, xfer_a, 0);
      check_eq({tag, "_data_a"}, data_a, 0);
      check_eq({tag, "_chid_a"}, chid_a, 0);
      check_eq({tag, "_rdy_a"},  rdy_a,  0);
      check_eq({tag, "_st_a"},   st_a,   S_IDLE);
      check_eq({tag, "_req_b"},  req_b,  0);
      check_eq({tag, "_xfer_b"}, xfer_b, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_a.delete();
      for (int c = 0; c < NCH; c++) src_a[c].delete();
      fire_a = '0;
      xfer_model_a = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_vals("rst");
      rst = 1'b0;
   endtask

   task automatic drain_a(input int max_cyc);
      bit ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         int pend = 0;
         @(negedge clk);
         #3;
         for (int c = 0; c < NCH; c++) pend += src_a[c].size();
         if (pend == 0 && !busy_a && vld_a == '0) ok = 1'b1;
      end
      if (!ok) check_eq("a_drain_timeout", ok, 1);
   endtask

   task automatic wait_req_a(input int max_cyc);
      bit ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         #3;
         if (req_a) ok = 1'b1;
      end
      if (!ok) check_eq("a_req_timeout", ok, 1);
   endtask

   task automatic send_b(input int ch, input logic [7:0] d, input logic exp_req, input int exp_cnt);
      logic [9:0] e;
      bit got = 1'b0;
      bit fin = 1'b0;
      exp_b.push_back({2'(ch), d});
      @(negedge clk);
      vld_b[ch] = 1'b1;
      din_b[ch*DW +: DW] = d;
      for (int i = 0; i < 100 && !got; i++) begin
         #1;
         if (rdy_b[ch]) begin
            got = 1'b1;
            @(posedge clk);
            #1;
            e = exp_b.pop_front();
            check_eq("b_accept", {chid_b, data_b}, e);
            check_eq("b_req_level", req_b, exp_req);
            check_eq("b_busy", busy_b, 1);
         end
         @(negedge clk);
      end
      vld_b[ch] = 1'b0;
      if (!got) check_eq("b_grant_timeout", got, 1);
      for (int i = 0; i < 100 && !fin; i++) begin
         @(negedge clk);
         #3;
         if (!busy_b) fin = 1'b1;
      end
      if (!fin) check_eq("b_done_timeout", fin, 1);
      check_eq("b_xfer_cnt", xfer_b, exp_cnt);
      check_eq("b_ack_matches", ack_b, req_b);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      vld_a = '0; din_a = '0; ack_a = 1'b0;
      vld_b = '0; din_b = '0; ack_b = 1'b0;
      do_reset();

      // 2-phase: three transfers, req toggles 1,0,1
      resp_en_b = 1'b1;
      send_b(1, 8'h04, 1'b1, 1);
      send_b(2, 8'h05, 1'b0, 2);
      send_b(0, 8'h0A, 1'b1, 3);
      check_eq("b_err", err_b, 0);

      // 4-phase single channel transfer
      do_reset();
      resp_en_a = 1'b1;
      rdy2_cnt = 0;
      exp_a.push_back({2'd2, 8'h5A});
      src_a[2].push_back(8'h5A);
      drain_a(200);
      check_eq("t1_data", data_a, 8'h5A);
      check_eq("t1_chid", chid_a, 2);
      check_eq("t1_xfer", xfer_a, 1);
      check_eq("t1_done_pulses", xfer_model_a, 1);
      check_eq("t1_rdy2_cycles", rdy2_cnt, 1);
      check_eq("t1_err", err_a, 0);

      // all channels valid from a fresh pointer: order 0,1,2,3,0
      do_reset();
      exp_a.push_back({2'd0, 8'h10});
      exp_a.push_back({2'd1, 8'h11});
      exp_a.push_back({2'd2, 8'h12});
      exp_a.push_back({2'd3, 8'h13});
      exp_a.push_back({2'd0, 8'h14});
      src_a[0].push_back(8'h10);
      src_a[0].push_back(8'h14);
      src_a[1].push_back(8'h11);
      src_a[2].push_back(8'h12);
      src_a[3].push_back(8'h13);
      drain_a(500);
      check_eq("t2_xfer", xfer_a, 5);
      check_eq("t2_exp_left", exp_a.size(), 0);
      check_eq("t2_err", err_a, 0);

      // timeout: silent far side for 16 waiting cycles, then a late ack
      resp_en_a = 1'b0;
      ack_a = 1'b0;
      exp_a.push_back({2'd0, 8'h77});
      src_a[0].push_back(8'h77);
      wait_req_a(50);
      repeat (15) @(posedge clk);
      #1;
      check_eq("t4_err_early", err_a, 0);
      @(posedge clk);
      #1;
      check_eq("t4_err_set", err_a, 1);
      check_eq("t4_busy", busy_a, 1);
      check_eq("t4_state", st_a, S_REQ);
      resp_en_a = 1'b1;
      drain_a(200);
      check_eq("t4_err_sticky", err_a, 1);
      check_eq("t4_xfer", xfer_a, 6);
      check_eq("t4_data", data_a, 8'h77);

      // reset in the middle of a handshake
      exp_a.push_back({2'd3, 8'h33});
      src_a[3].push_back(8'h33);
      wait_req_a(50);
      #1;
      rst = 1'b1;
      resp_en_a = 1'b0;
      ack_a = 1'b0;
      #1;
      check_eq("t5_req", req_a, 0);
      check_eq("t5_busy", busy_a, 0);
      check_eq("t5_data", data_a, 0);
      check_eq("t5_xfer", xfer_a, 0);
      check_eq("t5_err", err_a, 0);
      do_reset();
      resp_en_a = 1'b1;
      exp_a.push_back({2'd1, 8'hA5});
      src_a[1].push_back(8'hA5);
      drain_a(200);
      check_eq("t5_after_data", data_a, 8'hA5);
      check_eq("t5_after_chid", chid_a, 1);
      check_eq("t5_after_xfer", xfer_a, 1);

      // stale ack held high in IDLE blocks grants until it has synchronised low
      resp_en_a = 1'b0;
      ack_a = 1'b1;
      do_reset();
      repeat (3) @(negedge clk);
      exp_a.push_back({2'd0, 8'h66});
      src_a[0].push_back(8'h66);
      repeat (6) begin
         @(negedge clk);
         #3;
         check_eq("t6_stale_block", rdy_a, 0);
      end
      ack_a = 1'b0;
      @(posedge clk);
      #1;
      check_eq("t6_rdy_1edge", rdy_a[0], 0);
      @(posedge clk);
      #1;
      check_eq("t6_rdy_2edge", rdy_a[0], 1);
      resp_en_a = 1'b1;
      drain_a(200);
      check_eq("t6_xfer", xfer_a, 1);
      check_eq("t6_data", data_a, 8'h66);
      check_eq("t6_exp_left", exp_a.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
